// File: rtl/oam_dma_if.sv
// Bus bundle between the CPU-side decoder/memory and the OAM DMA sequencer.
// The sequencer is the master: it issues CPU bus reads and OAM writes.
interface oam_dma_if;
   logic        cpu_clk_en;
   logic        reg_we;
   logic [7:0]  reg_data;
   logic [7:0]  oam_start;
   logic [7:0]  mem_rdata;
   logic        dma_active;
   logic        mem_re;
   logic [15:0] mem_addr;
   logic        oam_we;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_wdata;
   logic        dma_done;

   modport master (
      input  cpu_clk_en, reg_we, reg_data, oam_start, mem_rdata,
      output dma_active, mem_re, mem_addr, oam_we, oam_addr, oam_wdata, dma_done
   );

   modport slave (
      output cpu_clk_en, reg_we, reg_data, oam_start, mem_rdata,
      input  dma_active, mem_re, mem_addr, oam_we, oam_addr, oam_wdata, dma_done
   );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA sequencer: a $4014 write halts the CPU and copies one CPU page into OAM as
// alternating READ/WRITE CPU cycles. Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN state.
module oam_dma #(
   parameter int XFER_LEN = 256   // power of two, at most 256
) (
   input  logic      clk,
   input  logic      rst_n,
   oam_dma_if.master bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

   state_t      state_reg;
   logic [7:0]  page_reg;
   logic [7:0]  base_reg;
   logic [7:0]  idx_reg;
   logic        dma_active_reg;
   logic        mem_re_reg;
   logic [15:0] mem_addr_reg;
   logic        oam_we_reg;
   logic [7:0]  oam_addr_reg;
   logic        dma_done_reg;
   logic [7:0]  idx_next;
   logic        idx_is_last;
`ifdef OAM_DMA_ALIGN_EN
   logic        cyc_odd_reg;
`endif

   assign idx_next    = idx_reg + 8'd1;
   assign idx_is_last = (idx_reg == IDX_LAST);

   // Outputs are registered together with the state they belong to, so each is a
   // pure function of the current state and the latched page/base/idx.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         page_reg       <= 8'h00;
         base_reg       <= 8'h00;
         idx_reg        <= 8'h00;
         dma_active_reg <= 1'b0;
         mem_re_reg     <= 1'b0;
         mem_addr_reg   <= 16'h0000;
         oam_we_reg     <= 1'b0;
         oam_addr_reg   <= 8'h00;
         dma_done_reg   <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
         cyc_odd_reg    <= 1'b0;
`endif
      end else if (bus.cpu_clk_en) begin
`ifdef OAM_DMA_ALIGN_EN
         cyc_odd_reg <= ~cyc_odd_reg;
`endif
         case (state_reg)
            IDLE: begin
               if (bus.reg_we) begin
                  page_reg       <= bus.reg_data;
                  base_reg       <= bus.oam_start;
                  idx_reg        <= 8'h00;
                  dma_active_reg <= 1'b1;
                  state_reg      <= HALT;
               end
            end
            HALT: begin
`ifdef OAM_DMA_ALIGN_EN
               if (cyc_odd_reg) begin
                  state_reg <= ALIGN;
               end else begin
                  state_reg    <= READ;
                  mem_re_reg   <= 1'b1;
                  mem_addr_reg <= {page_reg, idx_reg};
               end
`else
               state_reg    <= READ;
               mem_re_reg   <= 1'b1;
               mem_addr_reg <= {page_reg, idx_reg};
`endif
            end
            ALIGN: begin
               state_reg    <= READ;
               mem_re_reg   <= 1'b1;
               mem_addr_reg <= {page_reg, idx_reg};
            end
            READ: begin
               state_reg    <= WRITE;
               mem_re_reg   <= 1'b0;
               oam_we_reg   <= 1'b1;
               oam_addr_reg <= base_reg + idx_reg;
               dma_done_reg <= idx_is_last;
            end
            WRITE: begin
               oam_we_reg   <= 1'b0;
               dma_done_reg <= 1'b0;
               if (idx_is_last) begin
                  // A $4014 write landing here is dropped: we only sample it in IDLE.
                  dma_active_reg <= 1'b0;
                  state_reg      <= IDLE;
               end else begin
                  idx_reg      <= idx_next;
                  state_reg    <= READ;
                  mem_re_reg   <= 1'b1;
                  mem_addr_reg <= {page_reg, idx_next};
               end
            end
            default: begin
               state_reg      <= IDLE;
               dma_active_reg <= 1'b0;
               mem_re_reg     <= 1'b0;
               oam_we_reg     <= 1'b0;
               dma_done_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dma_active = dma_active_reg;
   assign bus.mem_re     = mem_re_reg;
   assign bus.mem_addr   = mem_addr_reg;
   assign bus.oam_we     = oam_we_reg;
   assign bus.oam_addr   = oam_addr_reg;
   assign bus.dma_done   = dma_done_reg;
   // Read data arrives in the WRITE cycle, so it feeds OAM directly.
   assign bus.oam_wdata  = bus.mem_rdata;
endmodule
